pwm_multi_channel: RTL

Parametrised successor to the single-channel up/down duty-cycle PWM. Drives CHANNELS independent PWM outputs, each with a complementary output, from one shared period counter. Two push-button-style inputs raise or lower the duty of the channel picked by a select bus. Duty changes are double-buffered so that a period is never truncated. The block sits directly behind the tile IO pins and needs no external logic.

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_channel.sv | 99 +++++++++
 rtl/pwm_multi_channel.sv | 83 ++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared helpers for the multi-channel PWM: duty/select widths and saturating duty steps.
package pwm_pkg;

    function automatic int duty_w(input int width);
        return width + 1;
    endfunction

    function automatic int sel_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int sat_step(input int value, input int step, input logic up,
                                    input int max_val);
        int res;
        if (up) begin
            res = (value + step > max_val) ? max_val : value + step;
        end else begin
            res = (value < step) ? 0 : value - step;
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty, compare against the shared counter, registered outputs.
// PWM_DEADTIME_EN adds per-output dead-time down-counters that delay each assertion.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int STEP       = 1,
    parameter int RESET_DUTY = 2 ** (WIDTH - 1),
    parameter int DEADTIME   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt,
    input  logic             wrap,
    input  logic             inc_press,
    input  logic             dec_press,
    output logic             pwm_out,
    output logic             neg_pwm_out
);
    localparam int DW   = duty_w(WIDTH);
    localparam int FULL = 2 ** WIDTH;

    if (DEADTIME < 1 || DEADTIME > FULL - 1) begin : g_bad_deadtime
        $error("pwm_channel: DEADTIME out of range");
    end

    logic [DW-1:0] duty_next_q, duty_next_d;
    logic [DW-1:0] duty_active_q, duty_active_d;
    logic          pwm_q, pwm_d;
    logic          neg_q, neg_d;
    logic          raw;

    always_comb begin
        duty_next_d = duty_next_q;
        if (inc_press) begin
            duty_next_d = DW'(sat_step(int'(duty_next_q), STEP, 1'b1, FULL));
        end else if (dec_press) begin
            duty_next_d = DW'(sat_step(int'(duty_next_q), STEP, 1'b0, FULL));
        end
        // The old duty_next is captured on the last count so a period never truncates.
        duty_active_d = wrap ? duty_next_q : duty_active_q;
    end

    assign raw = ({1'b0, cnt} < duty_active_q);

`ifdef PWM_DEADTIME_EN
    localparam logic [WIDTH-1:0] DT_LOAD = WIDTH'(DEADTIME);

    logic [WIDTH-1:0] pos_tmr_q, pos_tmr_d;
    logic [WIDTH-1:0] neg_tmr_q, neg_tmr_d;

    // Each timer reloads while its drive is low and counts down while high;
    // the output is allowed only once the timer has reached terminal count.
    always_comb begin
        pos_tmr_d = DT_LOAD;
        neg_tmr_d = DT_LOAD;
        if (raw) begin
            pos_tmr_d = (pos_tmr_q != '0) ? pos_tmr_q - WIDTH'(1) : pos_tmr_q;
        end else begin
            neg_tmr_d = (neg_tmr_q != '0) ? neg_tmr_q - WIDTH'(1) : neg_tmr_q;
        end
        pwm_d = raw & (pos_tmr_q == '0);
        neg_d = ~raw & (neg_tmr_q == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_tmr_q <= DT_LOAD;
            neg_tmr_q <= DT_LOAD;
        end else begin
            pos_tmr_q <= pos_tmr_d;
            neg_tmr_q <= neg_tmr_d;
        end
    end
`else
    always_comb begin
        pwm_d = raw;
        neg_d = ~raw;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_next_q   <= DW'(RESET_DUTY);
            duty_active_q <= DW'(RESET_DUTY);
            pwm_q         <= 1'b0;
            neg_q         <= 1'b0;
        end else begin
            duty_next_q   <= duty_next_d;
            duty_active_q <= duty_active_d;
            pwm_q         <= pwm_d;
            neg_q         <= neg_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign neg_pwm_out = neg_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM top: press synchronisers/edge detect, shared period counter, channel decode.
// Define PWM_DEADTIME_EN to enable dead-time insertion between pwm_out and neg_pwm_out.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int CHANNELS   = 2,
    parameter int STEP       = 1,
    parameter int RESET_DUTY = 2 ** (WIDTH - 1),
    parameter int DEADTIME   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         increase_duty_in,
    input  logic                         decrease_duty_in,
    input  logic [sel_w(CHANNELS)-1:0]   ch_sel,
    output logic [CHANNELS-1:0]          pwm_out,
    output logic [CHANNELS-1:0]          neg_pwm_out
);
    localparam int SW = sel_w(CHANNELS);

    if (CHANNELS < 1 || CHANNELS > 4) begin : g_bad_channels
        $error("pwm_multi_channel: CHANNELS out of range");
    end

    // Bits: [0] first sync stage, [1] second sync stage, [2] previous synced level.
    logic [2:0]          inc_pipe_q, inc_pipe_d;
    logic [2:0]          dec_pipe_q, dec_pipe_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic                inc_rise, dec_rise, wrap;
    logic [CHANNELS-1:0] inc_ch, dec_ch;

    always_comb begin
        inc_pipe_d = {inc_pipe_q[1:0], increase_duty_in};
        dec_pipe_d = {dec_pipe_q[1:0], decrease_duty_in};
        cnt_d      = cnt_q + WIDTH'(1);
    end

    assign inc_rise = inc_pipe_q[1] & ~inc_pipe_q[2];
    assign dec_rise = dec_pipe_q[1] & ~dec_pipe_q[2];
    assign wrap     = &cnt_q;

    // Simultaneous increase and decrease cancel; out-of-range selects match no channel.
    always_comb begin
        inc_ch = '0;
        dec_ch = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            inc_ch[i] = inc_rise & ~dec_rise & (ch_sel == SW'(i));
            dec_ch[i] = dec_rise & ~inc_rise & (ch_sel == SW'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_pipe_q <= '0;
            dec_pipe_q <= '0;
            cnt_q      <= '0;
        end else begin
            inc_pipe_q <= inc_pipe_d;
            dec_pipe_q <= dec_pipe_d;
            cnt_q      <= cnt_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pwm_channel #(
            .WIDTH      (WIDTH),
            .STEP       (STEP),
            .RESET_DUTY (RESET_DUTY),
            .DEADTIME   (DEADTIME)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .cnt         (cnt_q),
            .wrap        (wrap),
            .inc_press   (inc_ch[g]),
            .dec_press   (dec_ch[g]),
            .pwm_out     (pwm_out[g]),
            .neg_pwm_out (neg_pwm_out[g])
        );
    end

endmodule
